// File: rtl/sp_chunk_pkg.sv
// Shared state encoding, chunk layout indices and sizing for the secure chunk responder.
package sp_chunk_pkg;

  localparam int          NUM_CHUNKS        = 6;
  localparam int          CHUNK_W           = 64;
  localparam int          MSG_W             = 32;
  localparam logic [31:0] HDR_MAGIC_DEFAULT = 32'h5345_4350;

  localparam logic [2:0] CH_NONCE_LO = 3'd0;
  localparam logic [2:0] CH_NONCE_HI = 3'd1;
  localparam logic [2:0] CH_CT       = 3'd2;
  localparam logic [2:0] CH_TAG_LO   = 3'd3;
  localparam logic [2:0] CH_TAG_HI   = 3'd4;
  localparam logic [2:0] CH_HDR      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC_START,
    S_DEC_WAIT,
    S_ENC_START,
    S_ENC_WAIT,
    S_ENC_EMIT
  } state_t;

endpackage

// File: rtl/sp_chunk_buffer.sv
// Holds the six loaded chunks of a secure object plus a per-chunk valid mask.
module sp_chunk_buffer
  import sp_chunk_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_en,
  input  logic [2:0]                            wr_idx,
  input  logic [CHUNK_W-1:0]                    wr_data,
  input  logic                                  clr,
  output logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    chunks,
  output logic                                  all_valid
);

  logic [NUM_CHUNKS-1:0] mask_q;
  logic [NUM_CHUNKS-1:0] mask_d;

  // Clear wins over a write landing in the same cycle.
  always_comb begin
    mask_d = mask_q;
    if (clr) begin
      mask_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        if (wr_idx == 3'(i)) mask_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q    <= '0;
      all_valid <= 1'b0;
      chunks    <= '0;
    end else begin
      mask_q    <= mask_d;
      all_valid <= &mask_d;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        if (wr_en && !clr && wr_idx == 3'(i)) chunks[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/sp_chunk_responder.sv
// Engine-side responder for secure chunk load/store: drives the AEAD core to decrypt a
// buffered 6-chunk object or to encrypt a value and stream it out as 6 chunks.
module sp_chunk_responder
  import sp_chunk_pkg::*;
#(
  parameter logic [31:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 chunk_valid_i,
  input  logic [2:0]           chunk_idx_i,
  input  logic [CHUNK_W-1:0]   chunk_data_i,
  output logic                 chunks_loaded_o,
  input  logic                 decrpt_en_i,
  input  logic                 encrpt_en_i,
  input  logic [MSG_W-1:0]     plaintext_i,
  output logic                 asc_en_o,
  output logic                 encrypting_o,
  output logic                 decrypting_o,
  output logic [MSG_W-1:0]     enc_dec_message_o,
  output logic                 decryption_failed_o,
  output logic                 st_valid_o,
  input  logic                 st_ready_i,
  output logic [2:0]           st_idx_o,
  output logic [CHUNK_W-1:0]   st_data_o,
  output logic                 core_start_o,
  output logic                 core_mode_o,
  output logic [127:0]         core_nonce_o,
  output logic [CHUNK_W-1:0]   core_data_o,
  output logic [127:0]         core_tag_o,
  input  logic                 core_done_i,
  input  logic [CHUNK_W-1:0]   core_data_i,
  input  logic [127:0]         core_tag_i
);

  state_t                              state_q, state_d;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  chunks;
  logic                                buf_wr, dec_accept, enc_accept, dec_fail;
  logic [127:0]                        buf_nonce, buf_tag;
  logic [MSG_W-1:0]                    pt_q, msg_q;
  logic                                failed_q;
  logic [127:0]                        ctr_q, nonce_q, tag_q;
  logic [CHUNK_W-1:0]                  ct_q;
  logic [2:0]                          emit_idx_q;

  assign buf_nonce  = {chunks[CH_NONCE_HI], chunks[CH_NONCE_LO]};
  assign buf_tag    = {chunks[CH_TAG_HI], chunks[CH_TAG_LO]};
  assign buf_wr     = chunk_valid_i && (state_q == S_IDLE) && (chunk_idx_i < 3'(NUM_CHUNKS));
  assign dec_accept = (state_q == S_IDLE) && decrpt_en_i && chunks_loaded_o;
  assign enc_accept = (state_q == S_IDLE) && encrpt_en_i && !dec_accept;
  assign dec_fail   = (core_tag_i != buf_tag) || (core_data_i[63:32] != 32'h0) ||
                      (chunks[CH_HDR][63:32] != HDR_MAGIC);

  assign enc_dec_message_o   = msg_q;
  assign decryption_failed_o = failed_q;

  sp_chunk_buffer u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en     (buf_wr),
    .wr_idx    (chunk_idx_i),
    .wr_data   (chunk_data_i),
    .clr       (dec_accept),
    .chunks    (chunks),
    .all_valid (chunks_loaded_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    asc_en_o     = (state_q != S_IDLE);
    encrypting_o = 1'b0;
    decrypting_o = 1'b0;
    core_start_o = 1'b0;
    core_mode_o  = 1'b0;
    core_nonce_o = '0;
    core_data_o  = '0;
    core_tag_o   = '0;
    st_valid_o   = 1'b0;
    st_idx_o     = '0;
    st_data_o    = '0;
    case (state_q)
      S_IDLE: begin
        if (dec_accept)      state_d = S_DEC_START;
        else if (enc_accept) state_d = S_ENC_START;
      end
      S_DEC_START, S_DEC_WAIT: begin
        decrypting_o = 1'b1;
        core_start_o = (state_q == S_DEC_START);
        core_mode_o  = 1'b1;
        core_nonce_o = buf_nonce;
        core_data_o  = chunks[CH_CT];
        core_tag_o   = buf_tag;
        if (state_q == S_DEC_START) state_d = S_DEC_WAIT;
        else if (core_done_i)       state_d = S_IDLE;
      end
      S_ENC_START, S_ENC_WAIT: begin
        encrypting_o = 1'b1;
        core_start_o = (state_q == S_ENC_START);
        core_nonce_o = (state_q == S_ENC_START) ? ctr_q : nonce_q;
        core_data_o  = {32'h0, pt_q};
        if (state_q == S_ENC_START) state_d = S_ENC_WAIT;
        else if (core_done_i)       state_d = S_ENC_EMIT;
      end
      S_ENC_EMIT: begin
        encrypting_o = 1'b1;
        st_valid_o   = 1'b1;
        st_idx_o     = emit_idx_q;
        case (emit_idx_q)
          CH_NONCE_LO: st_data_o = nonce_q[63:0];
          CH_NONCE_HI: st_data_o = nonce_q[127:64];
          CH_CT:       st_data_o = ct_q;
          CH_TAG_LO:   st_data_o = tag_q[63:0];
          CH_TAG_HI:   st_data_o = tag_q[127:64];
          default:     st_data_o = {HDR_MAGIC, 32'h0};
        endcase
        if (st_ready_i && emit_idx_q == CH_HDR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The nonce counter skips zero on wrap so a fresh nonce is never the all-zero value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pt_q       <= '0;
      msg_q      <= '0;
      failed_q   <= 1'b0;
      ctr_q      <= 128'd1;
      nonce_q    <= '0;
      tag_q      <= '0;
      ct_q       <= '0;
      emit_idx_q <= '0;
    end else begin
      if (dec_accept) begin
        msg_q    <= '0;
        failed_q <= 1'b0;
      end
      if (enc_accept) pt_q <= plaintext_i;
      if (state_q == S_DEC_WAIT && core_done_i) begin
        failed_q <= dec_fail;
        msg_q    <= dec_fail ? '0 : core_data_i[31:0];
      end
      if (state_q == S_ENC_START) begin
        nonce_q <= ctr_q;
        ctr_q   <= (&ctr_q) ? 128'd1 : ctr_q + 128'd1;
      end
      if (state_q == S_ENC_WAIT && core_done_i) begin
        ct_q       <= core_data_i;
        tag_q      <= core_tag_i;
        emit_idx_q <= '0;
      end
      if (state_q == S_ENC_EMIT && st_ready_i) emit_idx_q <= emit_idx_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_sp_chunk_responder.sv
// Randomized self-checking bench for sp_chunk_responder with a toy AEAD core model.
module tb_sp_chunk_responder;
  import sp_chunk_pkg::*;

  typedef logic [5:0][63:0] chunks_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         chunk_valid_i;
  logic [2:0]   chunk_idx_i;
  logic [63:0]  chunk_data_i;
  logic         chunks_loaded_o;
  logic         decrpt_en_i, encrpt_en_i;
  logic [31:0]  plaintext_i;
  logic         asc_en_o, encrypting_o, decrypting_o;
  logic [31:0]  enc_dec_message_o;
  logic         decryption_failed_o;
  logic         st_valid_o, st_ready_i;
  logic [2:0]   st_idx_o;
  logic [63:0]  st_data_o;
  logic         core_start_o, core_mode_o;
  logic [127:0] core_nonce_o, core_tag_o;
  logic [63:0]  core_data_o;
  logic         core_done_i;
  logic [63:0]  core_data_i;
  logic [127:0] core_tag_i;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           done_cyc = 0;
  int           enc_starts = 0;
  int           force_delay = 0;
  logic [127:0] mdl_ctr;

  sp_chunk_responder dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .chunk_valid_i       (chunk_valid_i),
    .chunk_idx_i         (chunk_idx_i),
    .chunk_data_i        (chunk_data_i),
    .chunks_loaded_o     (chunks_loaded_o),
    .decrpt_en_i         (decrpt_en_i),
    .encrpt_en_i         (encrpt_en_i),
    .plaintext_i         (plaintext_i),
    .asc_en_o            (asc_en_o),
    .encrypting_o        (encrypting_o),
    .decrypting_o        (decrypting_o),
    .enc_dec_message_o   (enc_dec_message_o),
    .decryption_failed_o (decryption_failed_o),
    .st_valid_o          (st_valid_o),
    .st_ready_i          (st_ready_i),
    .st_idx_o            (st_idx_o),
    .st_data_o           (st_data_o),
    .core_start_o        (core_start_o),
    .core_mode_o         (core_mode_o),
    .core_nonce_o        (core_nonce_o),
    .core_data_o         (core_data_o),
    .core_tag_o          (core_tag_o),
    .core_done_i         (core_done_i),
    .core_data_i         (core_data_i),
    .core_tag_i          (core_tag_i)
  );

  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Toy stand-in for the AEAD core: XOR keystream from the nonce, tag from nonce and plaintext.
  function automatic logic [63:0] ks(input logic [127:0] n);
    return n[63:0] ^ {n[95:64], n[127:96]} ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  function automatic logic [127:0] tagf(input logic [127:0] n, input logic [63:0] p);
    return {n[127:64] + p, n[63:0] ^ {p[31:0], p[63:32]}} ^
           128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  initial begin
    bit           pending;
    int           cnt;
    logic         m;
    logic [127:0] n;
    logic [63:0]  d;
    core_done_i = 1'b0;
    core_data_i = '0;
    core_tag_i  = '0;
    pending     = 1'b0;
    forever begin
      @(negedge clk_i);
      core_done_i = 1'b0;
      if (rst_i) begin
        pending = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending     = 1'b0;
          core_done_i = 1'b1;
          core_data_i = d ^ ks(n);
          core_tag_i  = m ? tagf(n, d ^ ks(n)) : tagf(n, d);
          done_cyc    = cyc;
        end
      end else if (core_start_o) begin
        m = core_mode_o;
        n = core_nonce_o;
        d = core_data_o;
        if (!m) enc_starts++;
        cnt     = (force_delay > 0) ? force_delay : int'($urandom_range(1, 4));
        pending = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // All tasks are entered and left just after a falling clock edge.
  task automatic applyStimulus(input logic dec, input logic enc, input logic [31:0] pt);
    decrpt_en_i = dec;
    encrpt_en_i = enc;
    plaintext_i = pt;
    @(negedge clk_i);
    decrpt_en_i = 1'b0;
    encrpt_en_i = 1'b0;
  endtask

  task automatic loadChunk(input logic [2:0] idx, input logic [63:0] data);
    chunk_valid_i = 1'b1;
    chunk_idx_i   = idx;
    chunk_data_i  = data;
    @(negedge clk_i);
    chunk_valid_i = 1'b0;
  endtask

  task automatic loadAll(input chunks_t ch);
    int order[6];
    int j, tmp;
    for (int i = 0; i < 6; i++) order[i] = i;
    for (int i = 5; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    loadChunk(3'(order[0]), 64'($urandom) ^ {32'($urandom), 32'h0});
    for (int i = 0; i < 6; i++) loadChunk(3'(order[i]), ch[order[i]]);
    checkOutput("loaded_all", 128'(chunks_loaded_o), 128'(1));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_asc_en"},  128'(asc_en_o), 128'(0));
    checkOutput({tag, "_enc"},     128'(encrypting_o), 128'(0));
    checkOutput({tag, "_dec"},     128'(decrypting_o), 128'(0));
    checkOutput({tag, "_start"},   128'(core_start_o), 128'(0));
    checkOutput({tag, "_nonce"},   core_nonce_o, 128'(0));
    checkOutput({tag, "_cdata"},   128'(core_data_o), 128'(0));
    checkOutput({tag, "_st"},      128'({st_valid_o, st_idx_o, st_data_o}), 128'(0));
    checkOutput({tag, "_msg"},     128'({decryption_failed_o, enc_dec_message_o}), 128'(0));
    checkOutput({tag, "_loaded"},  128'(chunks_loaded_o), 128'(0));
  endtask

  task automatic runEncrypt(input logic [31:0] pt, input int stall_idx, input int stall_n,
                            output chunks_t ch);
    chunks_t      exp;
    logic [127:0] tg;
    int           hs, stalls;
    exp[0] = mdl_ctr[63:0];
    exp[1] = mdl_ctr[127:64];
    exp[2] = {32'h0, pt} ^ ks(mdl_ctr);
    tg     = tagf(mdl_ctr, {32'h0, pt});
    exp[3] = tg[63:0];
    exp[4] = tg[127:64];
    exp[5] = {32'h5345_4350, 32'h0};
    applyStimulus(1'b0, 1'b1, pt);
    checkOutput("enc_busy",  128'({asc_en_o, encrypting_o, decrypting_o}), 128'(3'b110));
    checkOutput("enc_start", 128'({core_start_o, core_mode_o}), 128'(2'b10));
    checkOutput("enc_nonce", core_nonce_o, mdl_ctr);
    checkOutput("enc_cdata", 128'(core_data_o), 128'({32'h0, pt}));
    mdl_ctr = (mdl_ctr == '1) ? 128'd1 : mdl_ctr + 128'd1;
    hs = 0;
    stalls = 0;
    for (int t = 0; t < 80 && hs < 6; t++) begin
      st_ready_i = 1'b0;
      if (st_valid_o) begin
        checkOutput("st_idx",  128'(st_idx_o), 128'(hs));
        checkOutput("st_data", 128'(st_data_o), 128'(exp[hs]));
        if (hs == stall_idx && stalls < stall_n) stalls++;
        else st_ready_i = ($urandom_range(0, 3) != 0);
        if (st_ready_i) hs++;
      end
      @(negedge clk_i);
    end
    st_ready_i = 1'b0;
    checkOutput("emit_count", 128'(hs), 128'(6));
    checkOutput("enc_idle", 128'({asc_en_o, encrypting_o, st_valid_o}), 128'(0));
    ch = exp;
  endtask

  task automatic decryptNow(input chunks_t ch, input logic enc_too);
    logic [127:0] n;
    logic [63:0]  p;
    logic         fail;
    n    = {ch[1], ch[0]};
    p    = ch[2] ^ ks(n);
    fail = (tagf(n, p) != {ch[4], ch[3]}) || (p[63:32] != 32'h0) ||
           (ch[5][63:32] != 32'h5345_4350);
    applyStimulus(1'b1, enc_too, 32'($urandom));
    checkOutput("dec_busy",  128'({asc_en_o, encrypting_o, decrypting_o}), 128'(3'b101));
    checkOutput("dec_start", 128'({core_start_o, core_mode_o}), 128'(2'b11));
    checkOutput("dec_nonce", core_nonce_o, n);
    checkOutput("dec_cdata", 128'(core_data_o), 128'(ch[2]));
    checkOutput("dec_ctag",  core_tag_o, {ch[4], ch[3]});
    checkOutput("dec_clear", 128'({chunks_loaded_o, decryption_failed_o, enc_dec_message_o}), 128'(0));
    for (int t = 0; t < 40 && decrypting_o; t++) @(negedge clk_i);
    checkOutput("dec_done", 128'({asc_en_o, decrypting_o}), 128'(0));
    checkOutput("dec_fall", 128'(cyc), 128'(done_cyc + 1));
    checkOutput("dec_failed", 128'(decryption_failed_o), 128'(fail));
    checkOutput("dec_msg", 128'(enc_dec_message_o), fail ? 128'(0) : 128'(p[31:0]));
  endtask

  initial begin
    chunks_t ch, bad;
    int      s, k;
    rst_i = 1'b1;
    chunk_valid_i = 1'b0; chunk_idx_i = '0; chunk_data_i = '0;
    decrpt_en_i = 1'b0; encrpt_en_i = 1'b0; plaintext_i = '0; st_ready_i = 1'b0;
    mdl_ctr = 128'd1;
    @(negedge clk_i);
    checkResetOutputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] roundtrip with backpressure at idx 2");
    runEncrypt(32'hDEAD_BEEF, 2, 3, ch);
    loadAll(ch);
    decryptNow(ch, 1'b0);
    checkOutput("rt_msg", 128'({decryption_failed_o, enc_dec_message_o}), 128'({1'b0, 32'hDEAD_BEEF}));

    $display("[TB] tag corruption");
    bad = ch;
    bad[3][0] = ~bad[3][0];
    loadAll(bad);
    decryptNow(bad, 1'b0);
    checkOutput("corrupt_failed", 128'(decryption_failed_o), 128'(1));

    $display("[TB] partial load and out-of-range indices");
    for (int i = 0; i < 5; i++) loadChunk(3'(i), ch[i]);
    loadChunk(3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    loadChunk(3'd7, 64'h1234_5678_9ABC_DEF0);
    checkOutput("partial_loaded", 128'(chunks_loaded_o), 128'(0));
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("partial_ignored", 128'({asc_en_o, decrypting_o}), 128'(0));
    loadChunk(3'd5, ch[5]);
    checkOutput("partial_done", 128'(chunks_loaded_o), 128'(1));
    decryptNow(ch, 1'b0);

    $display("[TB] simultaneous requests");
    loadAll(ch);
    s = enc_starts;
    decryptNow(ch, 1'b1);
    checkOutput("simul_no_enc", 128'(enc_starts), 128'(s));
    runEncrypt(32'($urandom), 6, 0, ch);

    $display("[TB] randomized roundtrips");
    for (int it = 0; it < 8; it++) begin
      runEncrypt(32'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), ch);
      k = int'($urandom_range(0, 6));
      if (k < 6) ch[k][$urandom_range(0, 63)] = ~ch[k][$urandom_range(0, 63)];
      loadAll(ch);
      decryptNow(ch, 1'b0);
    end

    $display("[TB] reset during encrypt wait");
    force_delay = 10;
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D);
    @(negedge clk_i);
    checkOutput("wait_state", 128'({encrypting_o, core_start_o}), 128'(2'b10));
    rst_i = 1'b1;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    force_delay = 0;
    mdl_ctr = 128'd1;
    @(negedge clk_i);
    runEncrypt(32'h0BAD_CAFE, 6, 0, ch);
    checkOutput("post_rst_nonce", {ch[1], ch[0]}, 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
